// File: rtl/serial_adder16_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_adder16_full_adder.sv
// One-bit full adder: two half adders whose carries are merged by an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic halfSum;
  logic halfCarry;
  logic propCarry;

  assign halfSum   = a ^ b;
  assign halfCarry = a & b;
  assign sum       = halfSum ^ cin;
  assign propCarry = halfSum & cin;
  assign cout      = halfCarry | propCarry;

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial unsigned adder: one result bit per RUN cycle, LSB first, with the
// finished sum and carry published on a one-cycle DONE state.
module serial_adder16
  import serial_adder16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               faSum;
  logic               faCout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (faSum),
    .cout (faCout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The final bit is folded straight into sum so it is valid on DONE entry.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = {faSum, psum_q[WIDTH-1:1]};
        carry_d = faCout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = {faSum, psum_q[WIDTH-1:1]};
          cout_d  = faCout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: fixed vectors, back-to-back, reset abort, random pairs.
`timescale 1ns/1ps
module tb_serial_adder16;
  import serial_adder16_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int totalChecks;
  int passedChecks;
  int overlapCount;
  int doneCount;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlapCount++;
    if (done) doneCount++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulse start with the given operands and wait for done; lat counts edges after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[5];
  int   lat;
  int   dc;
  logic [W-1:0] rx, ry;
  logic [W:0]   model;
  logic [W-1:0] ops[5];

  initial begin
    totalChecks = 0; passedChecks = 0; overlapCount = 0; doneCount = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;

    vecs[0] = '{a: 16'h0000, b: 16'h0000, sum: 16'h0000, cout: 1'b0};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, sum: 16'h5555, cout: 1'b0};
    vecs[2] = '{a: 16'h0001, b: 16'h0001, sum: 16'h0002, cout: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'h0001, sum: 16'h0000, cout: 1'b1};
    vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, sum: 16'hFFFE, cout: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset sum", 64'(sum), 64'd0);
    checkOutput("reset cout", 64'(cout), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(W));
      checkOutput($sformatf("vec%0d sum", i), 64'(sum), 64'(vecs[i].sum));
      checkOutput($sformatf("vec%0d cout", i), 64'(cout), 64'(vecs[i].cout));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done single pulse", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d idle after done", i), 64'(busy), 64'd0);
      checkOutput($sformatf("vec%0d sum held in idle", i), 64'({cout, sum}), 64'({vecs[i].cout, vecs[i].sum}));
    end

    // Back-to-back: start held high, operands changed while running.
    ops[0] = 16'h1111; ops[1] = 16'h8000; ops[2] = 16'hFFFF; ops[3] = 16'h00FF; ops[4] = 16'h0000;
    @(posedge clk); #1;
    a = ops[0]; b = ops[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      a = ops[k + 1]; b = ops[k + 1];
      if (k == 3) start = 1'b0;
      lat = 0;
      while (!done && lat < TIMEOUT) begin
        @(posedge clk); #1;
        lat++;
      end
      model = {1'b0, ops[k]} + {1'b0, ops[k]};
      checkOutput($sformatf("b2b%0d latency", k), 64'(lat), 64'(W));
      checkOutput($sformatf("b2b%0d cout,sum", k), 64'({cout, sum}), 64'(model));
      @(posedge clk); #1;
      checkOutput($sformatf("b2b%0d next busy", k), 64'(busy), (k < 3) ? 64'd1 : 64'd0);
    end

    // Start pulses during RUN must be ignored.
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = doneCount;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
      if (lat % 4 == 2 && lat < W - 1) begin
        a = 16'hDEAD; b = 16'hBEEF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("ignore-start latency", 64'(lat), 64'(W));
    checkOutput("ignore-start cout,sum", 64'({cout, sum}), 64'(17'h01010));
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ignore-start done count", 64'(doneCount - dc), 64'd1);

    // Reset in the middle of a run aborts without a done pulse.
    applyStimulus(16'h1234, 16'h4321, lat);
    checkOutput("pre-abort sum", 64'(sum), 64'h5555);
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = doneCount;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort sum", 64'(sum), 64'd0);
    checkOutput("abort cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort no done", 64'(doneCount - dc), 64'd0);
    checkOutput("abort sum held", 64'({cout, sum}), 64'd0);
    applyStimulus(16'h0003, 16'h0004, lat);
    checkOutput("post-reset latency", 64'(lat), 64'(W));
    checkOutput("post-reset cout,sum", 64'({cout, sum}), 64'h0007);

    // Random operand pairs against plain arithmetic.
    for (int i = 0; i < 1000; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      model = {1'b0, rx} + {1'b0, ry};
      applyStimulus(rx, ry, lat);
      checkOutput($sformatf("random a=0x%0h b=0x%0h sum=0x%0h cout=%0d (cout,sum)", rx, ry, sum, cout),
                  64'({cout, sum}), 64'(model));
    end

    checkOutput("busy/done overlap", 64'(overlapCount), 64'd0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/serial_adder16.md
SERIAL_ADDER16 -- requirements
Module: serial_adder16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request a new addition; sampled on rising clk.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured only on an accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured only on an accepted start.
REQ-007 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-008 SHALL have port: done  output  1  single-cycle pulse when sum/cout are updated.
REQ-009 SHALL have port: sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
REQ-010 SHALL have port: cout  output  1  registered carry-out of the last addition.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-012 SHALL accept start only in IDLE or DONE; an accepted start latches a, b into shift registers, clears the carry flop and the bit counter to 0, and moves the FSM to RUN.
REQ-013 SHALL ignore start while in RUN; operands and result registers are unaffected.
REQ-014 In RUN, each cycle SHALL add the LSBs of the two shift registers plus the carry flop, shift the sum bit into the MSB of a partial-sum register, shift both operand registers right by one, and update the carry flop with the generated carry.
REQ-015 SHALL count RUN cycles 0..WIDTH-1; on the cycle the counter equals WIDTH-1, it SHALL transition to DONE.
REQ-016 On entry to DONE, SHALL copy the partial-sum register into sum and the final carry into cout; done SHALL be 1 for exactly the DONE cycle.
REQ-017 DONE SHALL last one cycle, then move to IDLE, unless start is high in DONE, in which case it SHALL go directly to RUN (back-to-back operation).
REQ-018 Latency: start sampled high at edge N -> done high during the cycle after edge N+WIDTH; sum/cout valid from that same edge.
REQ-019 busy SHALL be 1 exactly in RUN; busy and done SHALL never be high together.
REQ-020 sum and cout SHALL hold their last values through IDLE and through any following RUN until the next DONE.
REQ-021 Arithmetic SHALL be unsigned; overflow wraps modulo 2^WIDTH with the carry reported only on cout.

Reset
REQ-022 reset SHALL asynchronously force: FSM=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand/partial-sum registers=0.
REQ-023 reset asserted mid-RUN SHALL abort the operation with no done pulse and no change to sum/cout other than clearing them to 0.
REQ-024 After reset deasserts, the first start SHALL be accepted on the first rising clk edge at which it is sampled high.

Structure
REQ-025 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in a shared package/include used by block and bench.
REQ-026 The per-bit adder SHALL be a single sub-module full_adder (a, b, cin -> sum, cout), built from two half adders plus an OR, instantiated once.
REQ-027 Counter width SHALL be clog2(WIDTH) bits.

Verification
REQ-028 a=0x0000, b=0x0000, start pulse -> done after 17 cycles, sum=0x0000, cout=0.
REQ-029 a=0x1234, b=0x4321 -> sum=0x5555, cout=0; a=0x0001, b=0x0001 -> sum=0x0002, cout=0.
REQ-030 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1; a=0xFFFF, b=0xFFFF -> sum=0xFFFE, cout=1.
REQ-031 Start held high continuously with new operands after each done -> back-to-back results, no IDLE cycle, one done per 17 cycles; start pulses during RUN produce no extra done.
REQ-032 reset asserted at RUN cycle 8 of a=0xAAAA, b=0x5555 -> busy=0, done never pulses, sum=0, cout=0; subsequent 0x0003+0x0004 -> sum=0x0007.
REQ-033 Bench SHALL compare {cout,sum} against a+b for 1000 random operand pairs and print FAIL lines with a, b, sum, cout on mismatch, "passed" otherwise.
